opl3_sample_scheduler: RTL and testbench

Paces the OPL3 synthesis pipeline at the native OPL3 sample rate (master clock / 288, 49715.9 Hz) by generating the one-cycle `sample_clk_en` pulse consumed by the operator and channel accumulation logic. It tracks whether each sample completes before the next one is due, measures worst-case completion latency, and gives host/reset logic a clean pause handshake so register state can be manipulated between samples. It sits alongside `channels` under the OPL3 top level.

---
 rtl/opl3_pkg.sv | 22 ++
 rtl/opl3_sample_scheduler_frac_clk_en.sv | 58 +++++
 rtl/opl3_sample_scheduler.sv | 158 +++++++++++++++
 tb/tb_opl3_sample_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// Shared OPL3 constants, scheduler state encoding and saturating-counter helpers.
package opl3_pkg;

    localparam longint unsigned OPL3_MASTER_CLK_HZ = 64'd14_318_180;
    localparam longint unsigned OPL3_CLK_DIV       = 64'd288;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_RUN       = 2'd2,
        ST_PAUSED    = 2'd3
    } sched_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/opl3_sample_scheduler_frac_clk_en.sv
// Fractional clock enable: adds INCREMENT every running cycle and flags each wrap
// of the accumulator past MODULUS, giving an average tick rate of INCREMENT/MODULUS.
module frac_clk_en #(
    parameter longint unsigned INCREMENT = 64'd1,
    parameter longint unsigned MODULUS   = 64'd2,
    parameter int unsigned     WIDTH     = 32'd34
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned W1 = WIDTH + 32'd1;
    localparam logic [WIDTH:0] INC_C = W1'(INCREMENT);
    localparam logic [WIDTH:0] MOD_C = W1'(MODULUS);

    if (INCREMENT >= MODULUS) begin : g_bad_ratio
        $error("frac_clk_en: INCREMENT must be smaller than MODULUS");
    end
    if ((MODULUS >> WIDTH) != 64'd0) begin : g_bad_width
        $error("frac_clk_en: WIDTH too small to hold MODULUS");
    end

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH:0]   sum_s;

    // Next accumulator value and wrap detection; one extra bit keeps the sum exact.
    always_comb begin
        sum_s  = {1'b0, acc_q} + INC_C;
        acc_d  = acc_q;
        tick_o = 1'b0;
        if (clear_i) begin
            acc_d = '0;
        end else if (run_i) begin
            if (sum_s >= MOD_C) begin
                acc_d  = WIDTH'(sum_s - MOD_C);
                tick_o = 1'b1;
            end else begin
                acc_d = sum_s[WIDTH-1:0];
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/opl3_sample_scheduler.sv
// Issues the per-sample start pulse at the OPL3 native rate, tracks sample completion,
// overruns and worst-case latency, and offers a pause handshake at sample boundaries.
module opl3_sample_scheduler
    import opl3_pkg::*;
#(
    parameter longint unsigned CLK_HZ    = 64'd50_000_000,
    parameter longint unsigned MASTER_HZ = OPL3_MASTER_CLK_HZ,
    parameter int unsigned     ACC_WIDTH = 32'd34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pause_req,
    input  logic        clear_stats,
    input  logic        sample_valid,
    output logic        sample_clk_en,
    output logic        busy,
    output logic        pause_ack,
    output logic        overrun,
    output logic [7:0]  overrun_count,
    output logic [15:0] sample_count,
    output logic [15:0] max_latency
);

    sched_state_e state_q, state_d;
    logic         tick_s;
    logic         acc_clear_s;
    logic         pulse_s;
    logic         ovr_event_s;
    logic         complete_s;

    logic         sample_clk_en_q;
    logic         busy_q;
    logic         pause_ack_q;
    logic         overrun_q, overrun_d;
    logic [7:0]   overrun_count_q, overrun_count_d;
    logic [15:0]  sample_count_q, sample_count_d;
    logic [15:0]  max_latency_q, max_latency_d;
    logic [15:0]  latency_q, latency_d;
    logic [7:0]   ovr_cnt_base_s;
    logic [15:0]  max_lat_base_s;

    // The accumulator only starts once the FSM has left IDLE, so phase restarts from zero.
    assign acc_clear_s = !enable || (state_q == ST_IDLE);

    frac_clk_en #(
        .INCREMENT (MASTER_HZ),
        .MODULUS   (CLK_HZ * OPL3_CLK_DIV),
        .WIDTH     (ACC_WIDTH)
    ) u_frac_clk_en (
        .clk_i   (clk),
        .reset_i (reset),
        .run_i   (enable),
        .clear_i (acc_clear_s),
        .tick_o  (tick_s)
    );

    // Sequencing: decide next state and which sample events happen this cycle.
    always_comb begin
        state_d     = state_q;
        pulse_s     = 1'b0;
        ovr_event_s = 1'b0;
        complete_s  = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_TICK;
                ST_WAIT_TICK: begin
                    if (pause_req) begin
                        state_d = ST_PAUSED;
                    end else if (tick_s) begin
                        pulse_s = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WAIT_TICK;
                    end
                end
                ST_RUN: begin
                    if (sample_valid) begin
                        complete_s = 1'b1;
                        if (pause_req) begin
                            state_d = ST_PAUSED;
                        end else if (tick_s) begin
                            pulse_s = 1'b1;
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_WAIT_TICK;
                        end
                    end else if (tick_s) begin
                        ovr_event_s = 1'b1;
                        pulse_s     = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSED: state_d = pause_req ? ST_PAUSED : ST_WAIT_TICK;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Statistics: clear_stats zeroes the base, then this cycle's events apply on top.
    always_comb begin
        ovr_cnt_base_s  = clear_stats ? 8'd0 : overrun_count_q;
        max_lat_base_s  = clear_stats ? 16'd0 : max_latency_q;
        overrun_d       = ovr_event_s ? 1'b1 : (clear_stats ? 1'b0 : overrun_q);
        overrun_count_d = ovr_event_s ? sat_inc8(ovr_cnt_base_s) : ovr_cnt_base_s;
        if (complete_s && (latency_q > max_lat_base_s)) begin
            max_latency_d = latency_q;
        end else begin
            max_latency_d = max_lat_base_s;
        end
        sample_count_d = pulse_s ? sample_count_q + 16'd1 : sample_count_q;
        if (pulse_s) begin
            latency_d = 16'd0;
        end else if (enable && (state_q == ST_RUN)) begin
            latency_d = sat_inc16(latency_q);
        end else begin
            latency_d = latency_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            sample_clk_en_q <= 1'b0;
            busy_q          <= 1'b0;
            pause_ack_q     <= 1'b0;
            overrun_q       <= 1'b0;
            overrun_count_q <= 8'd0;
            sample_count_q  <= 16'd0;
            max_latency_q   <= 16'd0;
            latency_q       <= 16'd0;
        end else begin
            state_q         <= state_d;
            sample_clk_en_q <= pulse_s;
            busy_q          <= (state_d == ST_RUN);
            pause_ack_q     <= (state_q == ST_PAUSED);
            overrun_q       <= overrun_d;
            overrun_count_q <= overrun_count_d;
            sample_count_q  <= sample_count_d;
            max_latency_q   <= max_latency_d;
            latency_q       <= latency_d;
        end
    end

    assign sample_clk_en = sample_clk_en_q;
    assign busy          = busy_q;
    assign pause_ack     = pause_ack_q;
    assign overrun       = overrun_q;
    assign overrun_count = overrun_count_q;
    assign sample_count  = sample_count_q;
    assign max_latency   = max_latency_q;

endmodule

// File: tb/tb_opl3_sample_scheduler.sv
// Directed bench: default-rate instance checked against an exact tick-time model,
// plus a fast-rate instance for overrun saturation, clear/overrun collision and reset.
module tb_opl3_sample_scheduler;

    localparam longint unsigned D_C = 64'd50_000_000 * 64'd288;
    localparam longint unsigned M_C = 64'd14_318_180;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, enable = 1'b0, pause_req = 1'b0, clear_stats = 1'b0, sample_valid = 1'b0;
    logic        sample_clk_en, busy, pause_ack, overrun;
    logic [7:0]  overrun_count;
    logic [15:0] sample_count, max_latency;

    logic        f_reset = 1'b1, f_enable = 1'b0, f_clear = 1'b0;
    logic        f_sample_clk_en, f_busy, f_pause_ack, f_overrun;
    logic [7:0]  f_overrun_count;
    logic [15:0] f_sample_count, f_max_latency;

    opl3_sample_scheduler u_dut (
        .clk(clk), .reset(reset), .enable(enable), .pause_req(pause_req),
        .clear_stats(clear_stats), .sample_valid(sample_valid),
        .sample_clk_en(sample_clk_en), .busy(busy), .pause_ack(pause_ack),
        .overrun(overrun), .overrun_count(overrun_count),
        .sample_count(sample_count), .max_latency(max_latency)
    );

    // Tick every 2 cycles exactly: D = 10*288 = 2880, increment 1440.
    opl3_sample_scheduler #(.CLK_HZ(64'd10), .MASTER_HZ(64'd1440), .ACC_WIDTH(32'd34)) u_fast (
        .clk(clk), .reset(f_reset), .enable(f_enable), .pause_req(1'b0),
        .clear_stats(f_clear), .sample_valid(1'b0),
        .sample_clk_en(f_sample_clk_en), .busy(f_busy), .pause_ack(f_pause_ack),
        .overrun(f_overrun), .overrun_count(f_overrun_count),
        .sample_count(f_sample_count), .max_latency(f_max_latency)
    );

    int checks = 0;
    int errors = 0;
    longint unsigned cyc = 64'd0;
    longint unsigned last_pulse = 64'd0;
    longint unsigned origin = 64'd0;

    typedef struct {
        int          resp;      // >0: valid this many cycles after pulse, 0: none, -1: on next tick
        logic        exp_ovr;
        logic [7:0]  exp_cnt;
        logic [15:0] exp_max;
    } vec_t;
    vec_t vecs[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin errors++; $display("FAIL %s actual=%0d expected=%0d", name, act, exp); end
    endtask
    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin errors++; $display("FAIL %s actual=%0d expected=%0d", name, act, exp); end
    endtask
    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin errors++; $display("FAIL %s actual=%0d expected=%0d", name, act, exp); end
    endtask
    task automatic chk64(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin errors++; $display("FAIL %s actual=%0d expected=%0d", name, act, exp); end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Cycle of the k-th pulse: first update n with n*M >= k*D, counted from the enable edge.
    function automatic longint unsigned t_of(input int k);
        return origin + (longint'(k) * D_C + M_C - 64'd1) / M_C;
    endfunction

    task automatic wait_pulse(input string name, input longint unsigned exp_cyc);
        while (!(sample_clk_en && cyc != last_pulse) && cyc < exp_cyc + 64'd20) step();
        chk64(name, cyc, exp_cyc);
        last_pulse = cyc;
    endtask

    task automatic main_outputs_zero(input string tag);
        chk1({tag, "_sample_clk_en"}, sample_clk_en, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_pause_ack"}, pause_ack, 1'b0);
        chk1({tag, "_overrun"}, overrun, 1'b0);
        chk8({tag, "_overrun_count"}, overrun_count, 8'd0);
        chk16({tag, "_sample_count"}, sample_count, 16'd0);
        chk16({tag, "_max_latency"}, max_latency, 16'd0);
    endtask

    initial begin
        int k;
        int npulse;
        longint unsigned lcoinc;
        longint unsigned xdrop;

        lcoinc = t_of(3) - 64'd1 - t_of(2);
        vecs[0] = '{200, 1'b0, 8'd0, 16'd0};
        vecs[1] = '{-1,  1'b0, 8'd0, 16'd200};
        vecs[2] = '{50,  1'b0, 8'd0, 16'(lcoinc)};
        vecs[3] = '{0,   1'b0, 8'd0, 16'(lcoinc)};
        vecs[4] = '{0,   1'b1, 8'd1, 16'(lcoinc)};
        vecs[5] = '{0,   1'b1, 8'd2, 16'(lcoinc)};
        vecs[6] = '{200, 1'b1, 8'd3, 16'(lcoinc)};
        vecs[7] = '{200, 1'b1, 8'd3, 16'(lcoinc)};

        repeat (3) step();
        reset = 1'b0;
        f_reset = 1'b0;
        main_outputs_zero("reset");

        // Fast instance: saturate overrun counter, collide clear with overrun, then reset.
        f_enable = 1'b1;
        step();
        cyc = 64'd0;
        while (cyc < 64'd2) step();
        chk1("fast_first_pulse", f_sample_clk_en, 1'b1);
        chk1("fast_busy", f_busy, 1'b1);
        while (cyc < 64'd604) step();
        chk8("fast_ovr_saturated", f_overrun_count, 8'd255);
        chk1("fast_overrun", f_overrun, 1'b1);
        chk16("fast_sample_count", f_sample_count, 16'd302);
        step();
        f_clear = 1'b1;
        step();
        f_clear = 1'b0;
        chk1("clear_vs_event_overrun", f_overrun, 1'b1);
        chk8("clear_vs_event_count", f_overrun_count, 8'd1);
        f_clear = 1'b1;
        step();
        f_clear = 1'b0;
        chk1("clear_alone_overrun", f_overrun, 1'b0);
        chk8("clear_alone_count", f_overrun_count, 8'd0);
        chk16("clear_alone_max", f_max_latency, 16'd0);
        step();
        f_reset = 1'b1;
        step();
        f_reset = 1'b0;
        f_enable = 1'b0;
        chk1("fast_rst_pulse", f_sample_clk_en, 1'b0);
        chk1("fast_rst_busy", f_busy, 1'b0);
        chk1("fast_rst_ack", f_pause_ack, 1'b0);
        chk1("fast_rst_overrun", f_overrun, 1'b0);
        chk8("fast_rst_count", f_overrun_count, 8'd0);
        chk16("fast_rst_samples", f_sample_count, 16'd0);
        chk16("fast_rst_max", f_max_latency, 16'd0);
        chk16("main_idle_samples", sample_count, 16'd0);

        // Main instance: table of per-sample responses with expected stats at each pulse.
        enable = 1'b1;
        step();
        cyc = 64'd0;
        origin = 64'd0;
        last_pulse = 64'd0;
        for (int i = 0; i < 8; i++) begin
            k = i + 1;
            wait_pulse("pulse_time", t_of(k));
            chk16("sample_count", sample_count, 16'(k));
            chk1("busy_at_pulse", busy, 1'b1);
            chk1("overrun", overrun, vecs[i].exp_ovr);
            chk8("overrun_count", overrun_count, vecs[i].exp_cnt);
            chk16("max_latency", max_latency, vecs[i].exp_max);
            if (vecs[i].resp > 0) begin
                while (cyc < t_of(k) + longint'(vecs[i].resp)) step();
                sample_valid = 1'b1;
                step();
                sample_valid = 1'b0;
                chk1("done_busy", busy, 1'b0);
            end else if (vecs[i].resp < 0) begin
                while (cyc < t_of(k + 1) - 64'd1) step();
                sample_valid = 1'b1;
                step();
                sample_valid = 1'b0;
                chk1("coinc_busy", busy, 1'b1);
                chk1("coinc_pulse", sample_clk_en, 1'b1);
            end
        end

        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        chk1("clear_overrun", overrun, 1'b0);
        chk8("clear_count", overrun_count, 8'd0);
        chk16("clear_max", max_latency, 16'd0);

        // Pause requested mid-RUN takes effect at completion.
        wait_pulse("pulse9_time", t_of(9));
        while (cyc < t_of(9) + 64'd10) step();
        pause_req = 1'b1;
        while (cyc < t_of(9) + 64'd100) step();
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk1("pause_entry_busy", busy, 1'b0);
        chk1("pause_ack_lag", pause_ack, 1'b0);
        chk16("pause_max_latency", max_latency, 16'd100);
        step();
        chk1("pause_ack_high", pause_ack, 1'b1);
        npulse = 0;
        for (int j = 0; j < 5000; j++) begin
            step();
            if (sample_clk_en) npulse++;
        end
        chk64("paused_pulses", longint'(npulse), 64'd0);
        chk1("pause_ack_hold", pause_ack, 1'b1);
        chk16("paused_sample_count", sample_count, 16'd9);
        xdrop = cyc;
        pause_req = 1'b0;
        step();
        chk1("pause_ack_fall_lag", pause_ack, 1'b1);
        step();
        chk1("pause_ack_fall", pause_ack, 1'b0);
        k = 1;
        while (t_of(k) < xdrop + 64'd2) k++;
        wait_pulse("resume_pulse_time", t_of(k));
        chk16("resume_sample_count", sample_count, 16'd10);

        // Disable mid-RUN: no pulses, stats frozen, valid ignored; re-enable restarts phase.
        xdrop = cyc;
        while (cyc < xdrop + 64'd20) step();
        enable = 1'b0;
        step();
        chk1("disable_busy", busy, 1'b0);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        npulse = 0;
        for (int j = 0; j < 3000; j++) begin
            step();
            if (sample_clk_en) npulse++;
        end
        chk64("idle_pulses", longint'(npulse), 64'd0);
        chk16("idle_sample_count", sample_count, 16'd10);
        chk16("idle_max_latency", max_latency, 16'd100);
        chk1("idle_overrun", overrun, 1'b0);
        chk8("idle_overrun_count", overrun_count, 8'd0);
        enable = 1'b1;
        origin = cyc + 64'd1;
        wait_pulse("reenable_pulse_time", t_of(1));
        chk16("reenable_sample_count", sample_count, 16'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
